// File: rtl/pc_return_stack.sv
// pc_return_stack: hardware return-address stack for the program counter load path.
// A push stores a return address. A pop presents the most recent address on d_out
// with a one-cycle load_out strobe that drives the counter's parallel-load input.
// Push and pop in the same cycle replace the top entry, which implements a tail call.
// Optional build macro: PC_STACK_CIRCULAR_EN. When it is defined, a push while full
// overwrites the oldest entry and does not set err.
module pc_return_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d_in,
    output logic [WIDTH-1:0]           d_out,
    output logic                       load_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // DEPTH is a power of two, so an AW-bit pointer wraps modulo DEPTH on its own.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             load_q, load_d;
    logic             err_q, err_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    sp_m1;
    logic             is_empty;
    logic             is_full;

    assign sp_m1    = sp_q - AW'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Next-state decode for pointer, occupancy, output register and error flag.
    always_comb begin
        sp_d      = sp_q;
        count_d   = count_q;
        d_out_d   = d_out_q;
        load_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q;

        unique case ({push, pop})
            2'b00: begin
                // Idle: state holds and the strobe drops.
            end
            2'b10: begin
                if (!is_full) begin
                    mem_we  = 1'b1;
                    sp_d    = sp_q + AW'(1);
                    count_d = count_q + CW'(1);
                end else begin
`ifdef PC_STACK_CIRCULAR_EN
                    // Overwrite the oldest entry; occupancy stays at DEPTH.
                    mem_we = 1'b1;
                    sp_d   = sp_q + AW'(1);
`else
                    err_d = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    d_out_d = mem[sp_m1];
                    sp_d    = sp_m1;
                    count_d = count_q - CW'(1);
                    load_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            2'b11: begin
                if (!is_empty) begin
                    // Tail-call replace: return the top and overwrite it in place.
                    d_out_d   = mem[sp_m1];
                    mem_we    = 1'b1;
                    mem_waddr = sp_m1;
                    load_d    = 1'b1;
                end else begin
                    // Empty stack: behaves as a plain push, which cannot overflow here.
                    mem_we  = 1'b1;
                    sp_d    = sp_q + AW'(1);
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Control state, with asynchronous clear that also cancels an in-flight strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q    <= '0;
            count_q <= '0;
            d_out_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            d_out_q <= d_out_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset is applied.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= d_in;
        end
    end

    assign d_out    = d_out_q;
    assign load_out = load_q;
    assign count    = count_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign err      = err_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack (DEPTH=8, WIDTH=16).
module tb_pc_return_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        load_out;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;

    pc_return_stack #(
        .WIDTH(16),
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .d_in     (d_in),
        .d_out    (d_out),
        .load_out (load_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] din;
        logic [15:0] dout;
        logic        load;
        logic [3:0]  cnt;
        logic        emp;
        logic        ful;
        logic        er;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic pu, input logic po, input logic [15:0] di,
                                input logic [15:0] dout, input logic ld, input logic [3:0] c,
                                input logic em, input logic fu, input logic er);
        vec_t v;
        v.push = pu; v.pop = po; v.din = di; v.dout = dout; v.load = ld;
        v.cnt = c; v.emp = em; v.ful = fu; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 2 ns later.
    task automatic step(input logic pu, input logic po, input logic [15:0] di);
        @(negedge clk);
        push = pu;
        pop  = po;
        d_in = di;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] dout, input logic ld,
                           input logic [3:0] c, input logic em, input logic fu,
                           input logic er);
        chk({tag, ".d_out"}, 32'(d_out), 32'(dout));
        chk({tag, ".load_out"}, 32'(load_out), 32'(ld));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".err"}, 32'(err), 32'(er));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        d_in  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    logic        ovf_err;
    logic [15:0] ovf_base;

    initial begin
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        d_in  = '0;

        // LIFO order, tail-call replace, push+pop on empty, underflow.
        vecs[0]  = mk(1, 0, 16'h0010, 16'h0000, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 16'h0020, 16'h0000, 0, 2, 0, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0030, 16'h0000, 0, 3, 0, 0, 0);
        vecs[3]  = mk(0, 1, 16'h0000, 16'h0030, 1, 2, 0, 0, 0);
        vecs[4]  = mk(0, 1, 16'h0000, 16'h0020, 1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 1, 16'h0000, 16'h0010, 1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 16'h0000, 16'h0010, 0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 16'h0080, 16'h0010, 0, 1, 0, 0, 0);
        vecs[8]  = mk(1, 1, 16'h0100, 16'h0080, 1, 1, 0, 0, 0);
        vecs[9]  = mk(0, 1, 16'h0000, 16'h0100, 1, 0, 1, 0, 0);
        vecs[10] = mk(1, 1, 16'h0055, 16'h0100, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 16'h0000, 16'h0055, 1, 0, 1, 0, 0);
        vecs[12] = mk(0, 1, 16'h0000, 16'h0055, 0, 0, 1, 0, 1);
        vecs[13] = mk(0, 0, 16'h0000, 16'h0055, 0, 0, 1, 0, 1);

        // Reset values, both while held and after release.
        repeat (2) @(negedge clk);
        chk_all("in_reset", 16'h0000, 0, 0, 1, 0, 0);
        reset = 1'b1;
        step(0, 0, 16'h0000);
        chk_all("post_reset", 16'h0000, 0, 0, 1, 0, 0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].load, vecs[i].cnt,
                    vecs[i].emp, vecs[i].ful, vecs[i].er);
        end

        // Sticky err clears only on reset.
        do_reset();
        step(0, 0, 16'h0000);
        chk("err_cleared", 32'(err), 32'd0);

        // Overflow: nine pushes into an eight-entry stack.
`ifdef PC_STACK_CIRCULAR_EN
        ovf_err  = 1'b0;
        ovf_base = 16'h0009;
`else
        ovf_err  = 1'b1;
        ovf_base = 16'h0008;
`endif
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 16'(i));
            chk($sformatf("ovf_push%0d.count", i), 32'(count), 32'(i));
        end
        chk("ovf_full_before", 32'(full), 32'd1);
        chk("ovf_err_before", 32'(err), 32'd0);
        step(1, 0, 16'h0009);
        chk("ovf_push9.count", 32'(count), 32'd8);
        chk("ovf_push9.full", 32'(full), 32'd1);
        chk("ovf_push9.err", 32'(err), 32'(ovf_err));
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 16'h0000);
            chk($sformatf("ovf_pop%0d.d_out", i), 32'(d_out), 32'(ovf_base - 16'(i)));
            chk($sformatf("ovf_pop%0d.load", i), 32'(load_out), 32'd1);
        end
        chk("ovf_drained.empty", 32'(empty), 32'd1);

        // Asynchronous reset cancels a strobe without waiting for an edge.
        do_reset();
        step(1, 0, 16'h0A01);
        step(1, 0, 16'h0A02);
        step(1, 0, 16'h0A03);
        chk("areset_pre.count", 32'(count), 32'd3);
        step(0, 1, 16'h0000);
        chk("areset_pop.d_out", 32'(d_out), 32'h0A03);
        chk("areset_pop.load", 32'(load_out), 32'd1);
        chk("areset_pop.count", 32'(count), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("areset.load", 32'(load_out), 32'd0);
        chk("areset.count", 32'(count), 32'd0);
        chk("areset.empty", 32'(empty), 32'd1);
        chk("areset.d_out", 32'(d_out), 32'd0);
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        reset = 1'b1;
        step(0, 0, 16'h0000);
        chk("areset_after.load", 32'(load_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Hardware return-address stack feeding the 16-bit program counter's load path. A call pushes a return address. A return pops the most recent address and presents it on `d_out` with a one-cycle `load_out` strobe, which drives the counter's `load` input directly. The block sits between the instruction decoder and the program counter and handles the counter's parallel-load port.

## Interface
Parameters:
- `WIDTH`, 16, address width in bits.
- `DEPTH`, 8, number of stack entries; must be a power of two, 2 or more.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `push` input, 1 bit: push `d_in` this cycle.
- `pop` input, 1 bit: pop the top entry this cycle.
- `d_in` input, WIDTH bits: return address to push.
- `d_out` output, WIDTH bits: registered popped address.
- `load_out` output, 1 bit: one-cycle strobe; `d_out` is valid while it is high.
- `empty` output, 1 bit: asserted when `count == 0`.
- `full` output, 1 bit: asserted when `count == DEPTH`.
- `count` output, $clog2(DEPTH)+1 bits: current occupancy.
- `err` output, 1 bit: sticky overflow/underflow flag.

## Operation
- Storage is a DEPTH×WIDTH register array, a stack pointer `sp` (index of the next free slot), and `count`.
- Reset (`reset` = 0) takes effect immediately:
  - `sp`, `count`, `d_out`, `load_out` and `err` all go to 0.
  - `empty` = 1 and `full` = 0.
  - Array contents are don't-care.
- Decision each rising edge, with `reset` = 1:
  - **Idle** (`push`=0, `pop`=0): no state change; `load_out` = 0.
  - **Push only, not full:** `mem[sp]` ← `d_in`; `sp`++; `count`++.
  - **Push only, full:** the push is dropped and `err` ← 1. Behaviour under `PC_STACK_CIRCULAR_EN` is given below.
  - **Pop only, not empty:** `d_out` ← `mem[sp-1]`; `sp`--; `count`--; `load_out` ← 1.
  - **Pop only, empty:** `d_out` holds its value; `load_out` ← 0; `err` ← 1.
  - **Push and pop together, not empty:** `d_out` ← `mem[sp-1]`; `mem[sp-1]` ← `d_in`; `sp` and `count` are unchanged; `load_out` ← 1. This is a tail-call replace.
  - **Push and pop together, empty:** treated as a push only. `err` is not set.
- `load_out` is cleared on every cycle that does not perform a successful pop.
- `err` clears only on reset.
- `sp` wraps modulo DEPTH. `count` saturates within 0..DEPTH.

## Timing
- Pop latency is one cycle: a pop sampled on edge N drives `d_out`/`load_out` valid after edge N, and they are consumed by the counter at edge N+1.
- A pop on edge N sees a push made on edge N−1; there is no bypass requirement beyond that.
- `empty`, `full` and `count` are registered, or derived combinationally from registered `count` only. They update after the edge that changes occupancy.
- Back-to-back pops on consecutive cycles produce consecutive `load_out` strobes with successive entries.
- Reset asserted mid-operation clears state asynchronously, without waiting for a clock edge. A strobe in flight is cancelled.

## Configuration
- Macro: `PC_STACK_CIRCULAR_EN`.
- **Defined:** a push while full overwrites the oldest entry.
  - `mem[sp]` ← `d_in` and `sp`++.
  - `count` stays at DEPTH.
  - `err` is not set.
  - The deepest return address is lost silently.
- **Undefined** (default): a push while full is dropped and `err` ← 1, as described in Operation.

## Test plan
- **Reset values:** hold `reset`=0, then release → `count`=0, `empty`=1, `full`=0, `load_out`=0, `d_out`=0x0000, `err`=0.
- **LIFO order:**
  - Push 0x0010, 0x0020, 0x0030, then pop three times.
  - Required: `d_out` = 0x0030, 0x0020, 0x0010 on consecutive cycles, with `load_out`=1 each cycle.
  - Afterwards `empty`=1 and `err`=0.
- **Simultaneous push and pop:**
  - With stack [0x0080], assert `push`=1, `pop`=1, `d_in`=0x0100.
  - Required: `d_out`=0x0080, `load_out`=1, `count` stays 1.
  - A following pop yields 0x0100.
- **Underflow:** pop with the stack empty → `load_out`=0, `d_out` unchanged, `err`=1 and remains 1 until reset.
- **Overflow with DEPTH=8:**
  - Push 0x0001 through 0x0009 (nine pushes).
  - Without the macro: `full`=1, `err`=1; eight pops return 0x0008 down to 0x0001.
  - With the macro: `err`=0; eight pops return 0x0009 down to 0x0002.
- **Asynchronous reset mid-operation:**
  - Pop with `count`=3, then drop `reset` mid-cycle before the next edge.
  - Required: `load_out` and `count` go to 0 immediately, without waiting for a clock edge.
